// File: rtl/raymarch_pkg.sv
// Shared constants and types for the raymarcher frame writer.
// Holds the default screen geometry, the frame-buffer address width,
// the packed RGB result type and the frame writer FSM state encoding.
package raymarch_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int CORDW         = 10;
  localparam int PIX_COUNT     = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int FB_ADDR_W     = 19;

  // One raymarcher result, packed as {red, green, blue}.
  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  // Frame writer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fw_state_t;

endpackage : raymarch_pkg

// File: rtl/raymarch_frame_writer_sync_fifo.sv
// Single-clock show-ahead FIFO (module sync_fifo).
// data_o always presents the oldest entry while empty_o is low; a pop
// simply advances the read pointer. DEPTH must be a power of two >= 2.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO may still push then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers; clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule : sync_fifo

// File: rtl/raymarch_frame_writer.sv
// Raymarcher frame writer.
// Scans pixel coordinates into the fixed-latency, non-stallable raymarcher
// pipeline, captures the RGB that emerges PIPE_LATENCY cycles later into a
// show-ahead FIFO, and writes results to the frame buffer in raster order.
// Issue is credit-gated: a credit is a FIFO slot reserved for a pixel in
// flight, so the pipeline can never deliver a result with nowhere to go.
// Write port handshake: a write transfers on any clock edge where
// o_wr_valid && i_wr_ready; while o_wr_valid is high and i_wr_ready low,
// o_wr_addr and o_wr_data hold, and o_wr_valid never drops without a transfer.
// Optional macro FRAME_AUTO_RESTART_EN: when defined, a finished frame
// restarts automatically one cycle after o_frame_done.
module raymarch_frame_writer
  import raymarch_pkg::*;
#(
  parameter int H_RES        = SCREEN_WIDTH,
  parameter int V_RES        = SCREEN_HEIGHT,
  parameter int PIPE_LATENCY = 300,
  parameter int FIFO_DEPTH   = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic [CORDW-1:0]     o_pixel_x,
  output logic [CORDW-1:0]     o_pixel_y,
  input  logic [7:0]           i_red,
  input  logic [7:0]           i_green,
  input  logic [7:0]           i_blue,
  output logic                 o_wr_valid,
  input  logic                 i_wr_ready,
  output logic [FB_ADDR_W-1:0] o_wr_addr,
  output logic [23:0]          o_wr_data
);

  localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CORDW-1:0]     X_LAST   = CORDW'(H_RES - 1);
  localparam logic [CORDW-1:0]     Y_LAST   = CORDW'(V_RES - 1);
  localparam logic [FB_ADDR_W-1:0] ADDR_LAST = FB_ADDR_W'(H_RES * V_RES - 1);
  localparam logic [CRED_W-1:0]    CRED_FULL = CRED_W'(FIFO_DEPTH);

  fw_state_t state_q, state_d;

  logic [CORDW-1:0]     x_q, x_d;
  logic [CORDW-1:0]     y_q, y_d;
  logic [CORDW-1:0]     pix_x_q, pix_x_d;
  logic [CORDW-1:0]     pix_y_q, pix_y_d;
  // Bit 0 marks the coordinates currently on o_pixel_x/y; bit k means those
  // coordinates were first presented k cycles ago, so bit PIPE_LATENCY lines
  // up with the matching RGB at the raymarcher outputs.
  logic [PIPE_LATENCY:0] valid_sr_q, valid_sr_d;
  logic [CRED_W-1:0]    credit_q, credit_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic                 frame_done_q, frame_done_d;

  logic  start_req;
  logic  start;
  logic  issue;
  logic  last_pix;
  logic  last_wr;
  rgb_t  cap_rgb;
  rgb_t  fifo_head;
  logic  fifo_push;
  logic  fifo_pop;
  logic  fifo_full;
  logic  fifo_empty;

`ifdef FRAME_AUTO_RESTART_EN
  assign start_req = i_start || frame_done_q;
`else
  assign start_req = i_start;
`endif

  assign start     = (state_q == ST_IDLE) && start_req;
  assign issue     = (state_q == ST_ISSUE) && (credit_q != '0);
  assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign fifo_push = valid_sr_q[PIPE_LATENCY];
  assign fifo_pop  = !fifo_empty && i_wr_ready;
  assign last_wr   = fifo_pop && (addr_q == ADDR_LAST);

  assign cap_rgb.red   = i_red;
  assign cap_rgb.green = i_green;
  assign cap_rgb.blue  = i_blue;

  sync_fifo #(
    .WIDTH ($bits(rgb_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (cap_rgb),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state logic for the frame FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_req) state_d = ST_ISSUE;
      ST_ISSUE: if (issue && last_pix) state_d = ST_DRAIN;
      ST_DRAIN: if (last_wr) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Raster scan, coordinate outputs, pipeline valid tracking and done pulse.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    valid_sr_d   = {valid_sr_q[PIPE_LATENCY-1:0], issue};
    frame_done_d = (state_q == ST_DRAIN) && last_wr;
    if (start) begin
      x_d = '0;
      y_d = '0;
    end else if (issue) begin
      pix_x_d = x_q;
      pix_y_d = y_q;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + CORDW'(1);
      end else begin
        x_d = x_q + CORDW'(1);
      end
    end
  end

  // Credit accounting and write address; a frame start refills credits.
  always_comb begin
    credit_d = credit_q;
    addr_d   = addr_q;
    if (start) begin
      credit_d = CRED_FULL;
      addr_d   = '0;
    end else begin
      unique case ({issue, fifo_pop})
        2'b10:   credit_d = credit_q - CRED_W'(1);
        2'b01:   credit_d = credit_q + CRED_W'(1);
        default: credit_d = credit_q;
      endcase
      if (fifo_pop) addr_d = addr_q + FB_ADDR_W'(1);
    end
  end

  // State and datapath registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      valid_sr_q   <= '0;
      credit_q     <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      valid_sr_q   <= valid_sr_d;
      credit_q     <= credit_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign o_frame_done = frame_done_q;
  assign o_pixel_x    = pix_x_q;
  assign o_pixel_y    = pix_y_q;
  assign o_wr_valid   = !fifo_empty;
  assign o_wr_addr    = addr_q;
  assign o_wr_data    = fifo_empty ? 24'd0 : fifo_head;

  // Credits guarantee a free slot for every result the pipeline delivers.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

  // Credits stay within the FIFO capacity.
  a_credit_range: assert property (@(posedge clk) disable iff (!rst_n)
    credit_q <= CRED_FULL);

endmodule : raymarch_frame_writer
